// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with a 2-entry skid buffer, synchronous
// flush with bubble insertion and a saturating stall-cycle counter.
module pipe_stage_skid #(
  parameter int unsigned           DATA_W  = 64,
  parameter logic [DATA_W-1:0]     RST_VAL = '0,
  parameter int unsigned           CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_a_rst_n,
  input  logic              i_s_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_cnt_clr,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StTwo   = 2'b10
  } state_e;

  state_e              r_state;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   r_skid;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_stall;

  // Handshake flags depend only on registered state, so o_ready never sees i_ready.
  assign o_valid     = (r_state != StEmpty);
  assign o_ready     = (r_state != StTwo);
  assign o_data      = r_main;
  assign o_stall_cnt = r_stall_cnt;

  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = o_valid & i_ready;
  assign w_stall    = o_valid & ~i_ready;

  // State and payload storage; flush overrides every handshake.
  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      r_state <= StEmpty;
      r_main  <= RST_VAL;
      r_skid  <= RST_VAL;
    end else if (i_s_rst) begin
      r_state <= StEmpty;
      r_main  <= RST_VAL;
      r_skid  <= RST_VAL;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_in_fire) begin
            r_main  <= i_data;
            r_state <= StOne;
          end
        end
        StOne: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= i_data;
          end else if (w_in_fire) begin
            r_skid  <= i_data;
            r_state <= StTwo;
          end else if (w_out_fire) begin
            // main keeps its last value while empty
            r_state <= StEmpty;
          end
        end
        StTwo: begin
          if (w_out_fire) begin
            r_main  <= r_skid;
            r_state <= StOne;
          end
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

  // Saturating stall counter; clear beats increment, flush leaves it alone.
  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised elastic pipeline stage register. It is the next generation of the fixed 32-bit stall/flush inter-stage register.
- Carries one DATA_W-wide payload (for example {instr, PC+4}) between MIPS32 pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer keeps full throughput under downstream back-pressure.
- Adds synchronous flush with bubble insertion and a saturating stall-cycle counter for performance monitoring.

Parameters:
- DATA_W, 64, payload width in bits.
- RST_VAL, 0, value loaded into both data registers on async reset and on flush (0 = MIPS NOP).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_a_rst_n  input  1  asynchronous active-low reset.
- i_s_rst  input  1  synchronous flush; kills all buffered entries.
- i_valid  input  1  upstream payload valid.
- o_ready  output  1  stage can accept a payload this cycle.
- i_data  input  DATA_W  upstream payload.
- o_valid  output  1  output payload valid.
- i_ready  input  1  downstream accepts this cycle.
- o_data  output  DATA_W  output payload, driven directly from the main register.
- i_cnt_clr  input  1  synchronous clear of the stall counter.
- o_stall_cnt  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-low, on i_a_rst_n. Reset values:
  - state = EMPTY.
  - main and skid data registers = RST_VAL.
  - o_valid = 0, o_ready = 1.
  - o_stall_cnt = 0.
- Handshake events:
  - in_fire = i_valid & o_ready.
  - out_fire = o_valid & i_ready.
- Storage: a main register drives o_data. A skid register holds one extra entry.
- State outputs:
  - o_valid = (state != EMPTY).
  - o_ready = (state != TWO). This is a pure function of registered state and has no combinational path from i_ready.
- Transitions when i_s_rst = 0:
  - EMPTY, in_fire: main <= i_data, go to ONE.
  - ONE, in_fire and out_fire: main <= i_data, stay in ONE.
  - ONE, in_fire and no out_fire: skid <= i_data, go to TWO.
  - ONE, out_fire and no in_fire: go to EMPTY; main holds its last value.
  - ONE, neither event: hold.
  - TWO, out_fire: main <= skid, go to ONE. No input is accepted because o_ready = 0.
  - TWO, no out_fire: hold everything.
- Latency and throughput:
  - 1 cycle from in_fire to o_valid when the stage starts EMPTY.
  - Sustains 1 transfer/cycle while i_ready stays high.
  - Payload order is strictly FIFO. No entry is duplicated or lost except by flush.
- Data registers load only on the accept and transfer events listed above. Otherwise they hold.
- o_data is don't-care when o_valid = 0. It holds either its last value or RST_VAL (after reset or flush).
- Flush (i_s_rst = 1) has priority over all handshake activity:
  - Next state is EMPTY.
  - main and skid are loaded with RST_VAL.
  - An in_fire in the flush cycle counts as consumed upstream but is discarded. This is correct for a whole-pipeline flush.
  - An out_fire in the flush cycle completes normally downstream, since the payload was presented that cycle.
  - o_ready is 1 in the cycle after the flush.
- Stall counter:
  - Increments by 1 on each cycle where o_valid = 1 and i_ready = 0.
  - Saturates at 2^CNT_W - 1 and does not wrap.
  - i_cnt_clr loads 0 and wins over a simultaneous increment.
  - Flush does not affect the counter. Async reset clears it.
- Assertion for the bench: o_ready = 0 and o_valid = 0 must never occur together. State encoding uses only EMPTY, ONE and TWO; the unused encoding returns to EMPTY.

Test Plan:
- Reset and single transfer: after release of i_a_rst_n, check o_valid = 0, o_ready = 1, o_data = 0. Drive i_valid = 1 with i_data = 0x0000_0004_2402_0005 for one cycle and hold i_ready = 1. Expect o_valid = 1 and o_data = 0x0000_0004_2402_0005 on the next cycle, then o_valid = 0.
- Streaming: send 8 back-to-back payloads 1..8 with i_ready = 1. Expect o_data = 1..8 on consecutive cycles with no bubbles and o_ready held at 1.
- Back-pressure and skid:
  - Stream 1,2,3 and drop i_ready in the cycle 1 is presented.
  - Expect state TWO holding 1 (main) and 2 (skid), and o_ready = 0 starting the next cycle.
  - Expect 3 to be held by upstream.
  - Raise i_ready; expect outputs 1,2,3 in order with none lost.
  - Expect o_stall_cnt equal to the number of stalled cycles.
- Flush in TWO: with state TWO, assert i_s_rst and i_valid together. Next cycle expect o_valid = 0, o_ready = 1 and o_data = RST_VAL. Expect no later output of the discarded entries.
- Counter saturation: with CNT_W = 4, hold o_valid = 1 and i_ready = 0 for 20 cycles. Expect o_stall_cnt = 15. Then assert i_cnt_clr while the stall continues; expect 0, then 1 on the following cycle.
- Async reset mid-stream: drop i_a_rst_n between clock edges while in state TWO. Expect all outputs to take their reset values immediately, without waiting for a clock edge.
